// File: rtl/pcs_tx_pkg.sv
// pcs_tx_pkg: ordered-set codes, extension code and FSM states shared by the PCS transmit stages
package pcs_tx_pkg;

    typedef enum logic [2:0] {
        OS_IDLE  = 3'd0,
        OS_DATA  = 3'd1,
        OS_START = 3'd2,
        OS_END   = 3'd3,
        OS_EXT_R = 3'd4,
        OS_ERR   = 3'd5
    } o_set_t;

    localparam logic [7:0] EXT_CODE_DEFAULT = 8'h0F;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START_WAIT,
        ST_PACKET,
        ST_EXTEND,
        ST_EPD2,
        ST_EPD2_ALIGN,
        ST_EPD3
    } state_t;

endpackage

// File: rtl/pcs_tx_ordered_set.sv
// pcs_tx_ordered_set: GMII to ordered-set command stage of the 1000BASE-X PCS transmit path
module pcs_tx_ordered_set
    import pcs_tx_pkg::*;
#(
    parameter bit         CARRIER_EXT_EN = 1'b1,
    parameter logic [7:0] EXT_CODE       = EXT_CODE_DEFAULT
) (
    input  logic       gtx_clk,
    input  logic       reset,
    input  logic [7:0] txd,
    input  logic       tx_en,
    input  logic       tx_er,
    input  logic       receiving,
    output logic [2:0] tx_o_set,
    output logic [7:0] tx_data,
    output logic       tx_even,
    output logic       transmitting,
    output logic       col,
    output logic       crs
);

    state_t state, state_nx;
    o_set_t o_nx;
    logic   even_nx, ext_hit, tx_nx;

    // parity of the slot being produced at the coming edge
    assign even_nx = ~tx_even;
    assign ext_hit = tx_er && txd == EXT_CODE;
    assign tx_nx   = o_nx != OS_IDLE;

    always_comb begin
        state_nx = state;
        o_nx     = OS_IDLE;
        case (state)
            ST_IDLE: if (tx_en) begin
                o_nx     = even_nx ? OS_START : OS_IDLE;
                state_nx = even_nx ? ST_PACKET : ST_START_WAIT;
            end
            ST_START_WAIT: begin
                o_nx     = OS_START;
                state_nx = ST_PACKET;
            end
            ST_PACKET: if (tx_en) begin
                o_nx = tx_er ? OS_ERR : OS_DATA;
            end else begin
                o_nx     = OS_END;
                state_nx = (CARRIER_EXT_EN && ext_hit) ? ST_EXTEND : ST_EPD2;
            end
            ST_EXTEND: begin
                o_nx     = (tx_er && !ext_hit) ? OS_ERR : OS_EXT_R;
                state_nx = tx_er ? ST_EXTEND : ST_EPD2_ALIGN;
            end
            ST_EPD2, ST_EPD2_ALIGN: begin
                o_nx     = OS_EXT_R;
                state_nx = even_nx ? ST_EPD3 : ST_IDLE;
            end
            ST_EPD3: begin
                o_nx     = OS_EXT_R;
                state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge gtx_clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            tx_o_set     <= OS_IDLE;
            tx_data      <= '0;
            tx_even      <= 1'b1;
            transmitting <= 1'b0;
            col          <= 1'b0;
            crs          <= 1'b0;
        end else begin
            state        <= state_nx;
            tx_o_set     <= o_nx;
            tx_data      <= (o_nx == OS_DATA) ? txd : '0;
            tx_even      <= even_nx;
            transmitting <= tx_nx;
            col          <= tx_nx & receiving;
            crs          <= tx_nx | receiving;
        end
    end

endmodule

// File: doc/pcs_tx_ordered_set.md
Name: pcs_tx_ordered_set

Overview:
Upstream stage of the transmit code-group encoder in the 1000BASE-X PCS transmit path (Clause 36 ordered-set process, xmit=DATA only). It consumes GMII txd/tx_en/tx_er and produces one ordered-set command per cycle, plus the data byte and even/odd parity, for the 8b/10b encoder. Its main jobs are:
- enforcing /S/ alignment and /T/R/(R) end-of-packet delimiters;
- carrier extension;
- error propagation;
- col/crs generation.

Parameters:
CARRIER_EXT_EN, 1, 1 = honour tx_er carrier extension after a frame; 0 = treat it as plain end of packet.
EXT_CODE, 8'h0F, txd value that qualifies carrier extension when tx_en=0 and tx_er=1.

Ports:
gtx_clk  input  1  transmit clock; all logic on the rising edge.
reset  input  1  synchronous, active-high reset.
txd  input  8  GMII transmit data.
tx_en  input  1  GMII transmit enable.
tx_er  input  1  GMII transmit error / carrier-extend qualifier.
receiving  input  1  receive process is active; used for col/crs.
tx_o_set  output  3  ordered-set command: IDLE, DATA, START, END, EXT_R, ERR (codes in package).
tx_data  output  8  byte to encode; valid when tx_o_set=DATA, 0 otherwise.
tx_even  output  1  1 = current code-group slot is even.
transmitting  output  1  packet in progress, /S/ through last /R/.
col  output  1  transmitting & receiving.
crs  output  1  transmitting | receiving.

Behaviour:
- Single clock domain. All outputs are registered. Inputs sampled at edge k drive outputs after edge k (one-cycle latency).
- Reset, applied synchronously at the edge with reset=1:
  - tx_o_set=IDLE, tx_data=0, tx_even=1, transmitting=0, col=0, crs=0, state=IDLE.
  - tx_even toggles every cycle after reset release.
- Reset mid-packet: return to reset values on the next edge. No /T/ is emitted.
- States:
  - IDLE: emit IDLE on both halves of the /I/ pair (even, odd).
    - tx_en=1 sampled with next slot even -> START.
    - Next slot odd -> emit IDLE (odd half) and go to START_WAIT. The byte sampled in that cycle is discarded (preamble shrink by one).
    - tx_er with tx_en=0 in IDLE is ignored.
  - START_WAIT: emit START (/S/) on the even slot and discard txd. Go to PACKET.
  - START: emit START on the even slot; the sampled byte (preamble) is replaced. Go to PACKET.
  - PACKET, per sampled input:
    - tx_en=1, tx_er=0 -> DATA, tx_data=txd.
    - tx_en=1, tx_er=1 -> ERR (/V/), tx_data=0.
    - tx_en=0 -> END (/T/). Next state is EXTEND if CARRIER_EXT_EN and tx_er=1 and txd=EXT_CODE; otherwise EPD2.
  - EXTEND:
    - tx_er=1 and txd=EXT_CODE -> EXT_R.
    - tx_er=1 with any other txd -> ERR.
    - tx_er=0 -> EXT_R, go to EPD2_ALIGN.
  - EPD2: emit EXT_R (/R/).
    - If this /R/ is on an even slot -> EPD3.
    - Otherwise -> IDLE.
  - EPD2_ALIGN: behaves exactly as EPD2.
  - EPD3: emit EXT_R on the odd slot, then go to IDLE. IDLE therefore always begins on an even slot.
- tx_en/txd sampled during EPD2/EPD3 are discarded. A frame starts only from the IDLE state; the inter-packet gap is the MAC's responsibility.
- transmitting is 1 on every cycle where tx_o_set is START, DATA, ERR, END or EXT_R. It is 0 in IDLE and START_WAIT.
- col and crs are registered from the next-state value of transmitting and the sampled receiving.
- tx_o_set never holds an undefined code; the default branch forces IDLE.

Decomposition:
- Package pcs_tx_pkg holds:
  - the tx_o_set encodings: IDLE=0, DATA=1, START=2, END=3, EXT_R=4, ERR=5;
  - EXT_CODE default;
  - the state enumeration.
  The downstream code-group encoder imports the same package.
- No sub-module: one FSM plus a parity flop (roughly 150-250 lines).

Test Plan:
- Aligned start: reset, then 2 cycles tx_en=0, then tx_en=1 with txd 0x55,0x55,0xD5,0x00..0x09 on an even slot -> outputs START then DATA 0x55,0xD5,0x00..0x09. transmitting rises with START.
- Misaligned start: tx_en rises with next slot odd -> IDLE (odd), START (even), then DATA from the third byte. The preamble is one byte shorter; there is no data shift afterwards.
- End parity: frame end with /T/ on an odd slot -> END, EXT_R (even), EXT_R (odd), IDLE (even). With /T/ on an even slot -> END, EXT_R, IDLE.
- Error propagation: tx_er=1 for one byte mid-frame (txd=0x3C) -> a single ERR, tx_data=0, DATA resumes on the next cycle.
- Carrier extension: tx_en falls with tx_er=1 and txd=0x0F for 3 cycles, then one cycle with txd=0x1F -> END, EXT_R x2, ERR, then closing EXT_R (plus alignment /R/ as needed), then IDLE. With CARRIER_EXT_EN=0 the same stimulus gives END/R/ only.
- Collision and reset: receiving=1 during a frame -> col=1 and crs=1 from the next edge. Asserting reset mid-DATA -> IDLE, tx_even=1, transmitting=0, col=0 after that edge, with no END emitted.
